// File: rtl/ubi_decode_if.sv
// Handshake and data bundle between a stochastic bitstream source/result consumer and ubi_decode.
interface ubi_decode_if #(
    parameter int INWD = 8
) ();
    logic            iStart;
    logic            iBit;
    logic            iBitEn;
    logic            iReady;
    logic            oBitRdy;
    logic [INWD-1:0] oB;
    logic            oSat;
    logic            oValid;

    modport master (
        output iStart, iBit, iBitEn, iReady,
        input  oBitRdy, oB, oSat, oValid
    );

    modport slave (
        input  iStart, iBit, iBitEn, iReady,
        output oBitRdy, oB, oSat, oValid
    );
endinterface

// File: rtl/ubi_decode.sv
// Bipolar stochastic-to-binary decoder: counts 1s over 2^INWD qualified bits into an offset-binary word.
// Define UBI_DEC_DBUF_EN to add a pending result buffer so a new window can start while a result waits.
//
// state | meaning
// IDLE  | waiting for iStart
// ACC   | counting qualified bits of the current window
// HOLD  | result (or pending result) waiting for the consumer; iStart ignored
module ubi_decode #(
    parameter int INWD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    ubi_decode_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [INWD-1:0] CNT_LAST = '1;

    state_t          state, state_nxt;
    logic [INWD-1:0] cnt;
    logic [INWD:0]   ones;
    logic [INWD:0]   n1;
    logic [INWD-1:0] res_b;
    logic            res_sat;
    logic            done;
    logic            xfer;
    logic            load_out;
    logic [INWD-1:0] out_b;
    logic            out_sat;
    logic            out_v;
`ifdef UBI_DEC_DBUF_EN
    logic            load_pend;
    logic            pend_to_out;
    logic [INWD-1:0] pend_b;
    logic            pend_sat;
`endif

    // The final qualified bit is folded in here so completion needs no extra cycle.
    assign n1      = ones + {{INWD{1'b0}}, bus.iBit};
    assign res_sat = n1[INWD];
    assign res_b   = res_sat ? '1 : n1[INWD-1:0];
    assign done    = (state == ACC) && bus.iBitEn && (cnt == CNT_LAST);
    assign xfer    = out_v && bus.iReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
`ifdef UBI_DEC_DBUF_EN
        load_pend   = 1'b0;
        pend_to_out = 1'b0;
`endif
        case (state)
            IDLE: if (bus.iStart) state_nxt = ACC;
            ACC: begin
                if (done) begin
`ifdef UBI_DEC_DBUF_EN
                    if (!out_v || xfer) begin
                        load_out  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        load_pend = 1'b1;
                        state_nxt = HOLD;
                    end
`else
                    load_out  = 1'b1;
                    state_nxt = HOLD;
`endif
                end
            end
            HOLD: begin
                if (xfer) begin
                    state_nxt = IDLE;
`ifdef UBI_DEC_DBUF_EN
                    pend_to_out = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            ones <= '0;
        end else if (state == IDLE && bus.iStart) begin
            cnt  <= '0;
            ones <= '0;
        end else if (state == ACC && bus.iBitEn) begin
            cnt  <= cnt + 1'b1;
            ones <= done ? '0 : n1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_b   <= '0;
            out_sat <= 1'b0;
            out_v   <= 1'b0;
        end else if (load_out) begin
            out_b   <= res_b;
            out_sat <= res_sat;
            out_v   <= 1'b1;
`ifdef UBI_DEC_DBUF_EN
        end else if (pend_to_out) begin
            out_b   <= pend_b;
            out_sat <= pend_sat;
            out_v   <= 1'b1;
`endif
        end else if (xfer) begin
            out_v   <= 1'b0;
        end
    end

`ifdef UBI_DEC_DBUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_b   <= '0;
            pend_sat <= 1'b0;
        end else if (load_pend) begin
            pend_b   <= res_b;
            pend_sat <= res_sat;
        end
    end
`endif

    assign bus.oBitRdy = (state == ACC);
    assign bus.oB      = out_b;
    assign bus.oSat    = out_sat;
    assign bus.oValid  = out_v;
endmodule

// File: tb/tb_ubi_decode.sv
// Scoreboard bench for ubi_decode at INWD=4: stimulus pushes expected results, a monitor pops on transfer.
module tb_ubi_decode;
    localparam int INWD = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [INWD-1:0] b;
        logic            sat;
    } res_t;

    res_t exp_q[$];

    ubi_decode_if #(.INWD(INWD)) bus ();

    ubi_decode #(.INWD(INWD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic en);
        bus.iBit   = b;
        bus.iBitEn = en;
        tick();
    endtask

    // One full window with iBitEn held high; leaves the bench right after the completing edge.
    task automatic window(input logic [15:0] bits, input int exp_b, input logic exp_sat, input string name);
        exp_q.push_back('{b: exp_b[INWD-1:0], sat: exp_sat});
        start();
        chk({name, "_bitrdy"}, int'(bus.oBitRdy), 1);
        for (int i = 0; i < 16; i++) begin
            send_bit(bits[i], 1'b1);
            if (i == 14) chk({name, "_early_valid"}, int'(bus.oValid), 0);
        end
        bus.iBitEn = 1'b0;
        bus.iBit   = 1'b0;
        chk({name, "_latency_valid"}, int'(bus.oValid), 1);
    endtask

    // Monitor: pops on every transfer and checks output stability while stalled.
    logic            stall_prev = 1'b0;
    logic [INWD-1:0] prev_b;
    logic            prev_sat;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!bus.oValid || bus.oB !== prev_b || bus.oSat !== prev_sat) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%0b b=%0d sat=%0b, expected valid=1 b=%0d sat=%0b",
                             bus.oValid, bus.oB, bus.oSat, prev_b, prev_sat);
                end
            end
            if (bus.oValid && bus.iReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got b=%0d sat=%0b, expected no transfer", bus.oB, bus.oSat);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    if (bus.oB !== e.b || bus.oSat !== e.sat) begin
                        errors++;
                        $display("FAIL result: got b=%0d sat=%0b, expected b=%0d sat=%0b",
                                 bus.oB, bus.oSat, e.b, e.sat);
                    end
                end
            end
            stall_prev = bus.oValid && !bus.iReady;
            prev_b     = bus.oB;
            prev_sat   = bus.oSat;
        end
    end

    initial begin
        rst_n      = 1'b0;
        bus.iStart = 1'b0;
        bus.iBit   = 1'b0;
        bus.iBitEn = 1'b0;
        bus.iReady = 1'b1;
        tick();
        tick();
        chk("reset_valid",  int'(bus.oValid),  0);
        chk("reset_b",      int'(bus.oB),      0);
        chk("reset_sat",    int'(bus.oSat),    0);
        chk("reset_bitrdy", int'(bus.oBitRdy), 0);
        rst_n = 1'b1;
        tick();

        // Basic windows: saturation, bipolar zero, all zeros, one short of saturation.
        window(16'hFFFF, 15, 1'b1, "all_ones");
        tick();
        chk("all_ones_pulse", int'(bus.oValid), 0);
        chk("all_ones_idle",  int'(bus.oBitRdy), 0);
        window(16'h5555, 8, 1'b0, "alternating");
        tick();
        window(16'h0000, 0, 1'b0, "all_zeros");
        tick();
        window(16'h7FFF, 15, 1'b0, "fifteen_ones");
        tick();

        // Gapped window: unqualified cycles carry iBit=1 and must not count.
        exp_q.push_back('{b: 4'd5, sat: 1'b0});
        start();
        begin
            int q;
            q = 0;
            for (int i = 0; i < 30; i++) begin
                if (i < 28 && (i % 2) == 1) begin
                    send_bit(1'b1, 1'b0);
                    chk("gap_bitrdy", int'(bus.oBitRdy), 1);
                end else begin
                    send_bit(q < 5, 1'b1);
                    q++;
                end
                if (i == 28) chk("gap_early_valid", int'(bus.oValid), 0);
            end
        end
        bus.iBitEn = 1'b0;
        bus.iBit   = 1'b0;
        chk("gap_latency_valid", int'(bus.oValid), 1);
        tick();

        // Consumer stall after completion.
        bus.iReady = 1'b0;
        window(16'h1111, 4, 1'b0, "stall");
`ifdef UBI_DEC_DBUF_EN
        tick();
        tick();
        window(16'h0007, 3, 1'b0, "second");
        chk("dbuf_hold_bitrdy", int'(bus.oBitRdy), 0);
        chk("dbuf_hold_b",      int'(bus.oB),      4);
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        tick();
        chk("dbuf_hold_start_ignored", int'(bus.oBitRdy), 0);
        bus.iReady = 1'b1;
        tick();
        chk("dbuf_second_valid", int'(bus.oValid), 1);
        chk("dbuf_second_b",     int'(bus.oB),     3);
        tick();
        chk("dbuf_drained_valid",  int'(bus.oValid),  0);
        chk("dbuf_drained_bitrdy", int'(bus.oBitRdy), 0);
`else
        for (int i = 0; i < 10; i++) begin
            bus.iStart = (i == 3);
            bus.iBit   = 1'b1;
            bus.iBitEn = 1'b1;
            tick();
            chk("hold_bitrdy", int'(bus.oBitRdy), 0);
            chk("hold_valid",  int'(bus.oValid),  1);
        end
        bus.iStart = 1'b0;
        bus.iBitEn = 1'b0;
        bus.iBit   = 1'b0;
        bus.iReady = 1'b1;
        tick();
        chk("hold_release_valid", int'(bus.oValid), 0);
        for (int i = 0; i < 4; i++) tick();
        chk("hold_no_spurious_valid",  int'(bus.oValid),  0);
        chk("hold_no_spurious_bitrdy", int'(bus.oBitRdy), 0);
`endif
        bus.iReady = 1'b1;
        tick();

        // Abort mid-window with reset, then confirm no residue.
        start();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
        bus.iBitEn = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid",  int'(bus.oValid),  0);
        chk("abort_b",      int'(bus.oB),      0);
        chk("abort_bitrdy", int'(bus.oBitRdy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        window(16'hFFFF, 15, 1'b1, "post_abort_ones");
        tick();
        window(16'h0001, 1, 1'b0, "post_abort_one");
        tick();
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
